// File: rtl/int_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_pkg
//  Description : Shared definitions for the interrupt controller. Contains the
//                ESTAT.IS bit layout and the controller FSM state encoding.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package int_pkg;

    // Fixed low part of the IS vector: two software bits, then hardware lines.
    localparam int unsigned SWI0     = 0;
    localparam int unsigned SWI1     = 1;
    localparam int unsigned HWI_BASE = 2;

    // Timer and IPI sit above the external lines and one reserved bit, so
    // their position moves with the number of external lines.
    function automatic int unsigned ti_bit(input int unsigned num_ext);
        return num_ext + 3;
    endfunction

    function automatic int unsigned ipi_bit(input int unsigned num_ext);
        return num_ext + 4;
    endfunction

    // Positions for the default 8-line configuration.
    localparam int unsigned TI_BIT  = ti_bit(8);
    localparam int unsigned IPI_BIT = ipi_bit(8);

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } int_state_e;

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync_edge
//  Description : One interrupt line: multi-flop synchroniser, rising-edge
//                detector and a pending flop with set-over-clear priority.
//                In level mode the output is the last synchroniser stage and
//                the clear input has no effect.
//  Ports       : clk    in  core clock
//                rst_n  in  asynchronous active-low reset
//                irq_in in  asynchronous interrupt line
//                clr    in  clear pulse for the edge-latched pending bit
//                pend   out pending (edge mode) or synchronised level
//  Revision    : 1.0  initial release
// ============================================================================
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE        = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    input  logic clr,
    output logic pend
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   pend_q;
    logic                   pend_d;
    logic                   w_sync;
    logic                   w_rise;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
        w_sync = sync_q[SYNC_STAGES-1];
        prev_d = w_sync;
        w_rise = w_sync & ~prev_q;
        // A new edge in the same cycle as a clear must not be lost.
        pend_d = w_rise | (pend_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    generate
        if (EDGE) begin : g_edge
            assign pend = pend_q;
        end else begin : g_level
            assign pend = w_sync;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/int_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_v2
//  Description : Interrupt controller for the 5-stage core. Builds the
//                ESTAT.IS pending vector from software, external, timer and
//                IPI sources, picks the highest enabled index and runs a
//                request/ack/service handshake with the WB stage.
//  Ports       : clk, rst_n          clock, async active-low reset
//                ext_irq[NUM_EXT]    async external lines
//                timer_irq, ipi_irq  timer (edge) and IPI (level) lines
//                swi[2]              software interrupt bits (synchronous)
//                timer_clr, is_clr   clears for edge-latched pending bits
//                gie, ecfg_lie       global and per-source enables
//                estat_is            pending vector to ESTAT.IS
//                int_req, int_cause  request and winning IS index
//                int_ack, wb_pc      WB accept and its PC
//                int_pc              PC captured on accept (ERA source)
//                ertn, in_service    handler return and handler-active flag
//  Revision    : 1.0  initial release
// ============================================================================
module int_ctrl_v2
    import int_pkg::*;
#(
    parameter  int unsigned NUM_EXT     = 8,
    parameter  int unsigned SYNC_STAGES = 2,
    parameter  logic [7:0]  EDGE_MASK   = 8'hFF,
    parameter  int unsigned PC_W        = 32,
    parameter  int unsigned CAUSE_W     = 6,
    localparam int unsigned IS_W        = NUM_EXT + 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_EXT-1:0] ext_irq,
    input  logic               timer_irq,
    input  logic               ipi_irq,
    input  logic [1:0]         swi,
    input  logic               timer_clr,
    input  logic [IS_W-1:0]    is_clr,
    input  logic               gie,
    input  logic [IS_W-1:0]    ecfg_lie,
    output logic [IS_W-1:0]    estat_is,
    output logic               int_req,
    output logic [CAUSE_W-1:0] int_cause,
    input  logic               int_ack,
    input  logic [PC_W-1:0]    wb_pc,
    output logic [PC_W-1:0]    int_pc,
    input  logic               ertn,
    output logic               in_service
);

    localparam int unsigned c_TI_BIT  = ti_bit(NUM_EXT);
    localparam int unsigned c_IPI_BIT = ipi_bit(NUM_EXT);
    localparam int unsigned c_RSV_BIT = NUM_EXT + 2;

    // ------------------------------------------------------------------
    // Per-line synchronisation and pending capture
    // ------------------------------------------------------------------
    logic [NUM_EXT-1:0] w_ext_pend;
    logic               w_ti_pend;
    logic               w_ipi_pend;

    generate
        for (genvar i = 0; i < NUM_EXT; i++) begin : g_ext
            irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES),
                .EDGE        (EDGE_MASK[i])
            ) u_line (
                .clk    (clk),
                .rst_n  (rst_n),
                .irq_in (ext_irq[i]),
                .clr    (is_clr[HWI_BASE+i]),
                .pend   (w_ext_pend[i])
            );
        end
    endgenerate

    // The timer can be cleared either through TICLR or through its IS bit.
    irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE        (1'b1)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (timer_irq),
        .clr    (timer_clr | is_clr[c_TI_BIT]),
        .pend   (w_ti_pend)
    );

    irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE        (1'b0)
    ) u_ipi (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (ipi_irq),
        .clr    (1'b0),
        .pend   (w_ipi_pend)
    );

    // Clear bits for software, reserved and IPI positions have no target.
    logic w_unused_clr;
    assign w_unused_clr = ^{is_clr[SWI1:SWI0], is_clr[c_RSV_BIT], is_clr[c_IPI_BIT]};

    // Software bits are already synchronous and pass straight through.
    assign estat_is = {w_ipi_pend, w_ti_pend, 1'b0, w_ext_pend, swi};

    // ------------------------------------------------------------------
    // Fixed-priority arbitration: highest enabled index wins
    // ------------------------------------------------------------------
    logic [IS_W-1:0]    w_en;
    logic               w_any_en;
    logic [CAUSE_W-1:0] w_win;
    logic               w_cause_en;

    int_state_e         state_q;
    int_state_e         state_d;
    logic [CAUSE_W-1:0] cause_q;
    logic [CAUSE_W-1:0] cause_d;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;

    always_comb begin
        w_en       = estat_is & ecfg_lie;
        w_any_en   = |w_en;
        w_win      = '0;
        w_cause_en = 1'b0;
        for (int i = 0; i < int'(IS_W); i++) begin
            if (w_en[i]) begin
                w_win = CAUSE_W'(i);
            end
            // Enable bit of the source frozen in cause_q.
            if (cause_q == CAUSE_W'(i)) begin
                w_cause_en = w_en[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        pc_d       = pc_q;
        int_req    = 1'b0;
        in_service = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (gie && w_any_en) begin
                    state_d = ST_REQ;
                    cause_d = w_win;
                end
            end
            ST_REQ: begin
                int_req = 1'b1;
                // Accept takes precedence over a simultaneous withdraw; a
                // newly arrived higher source does not replace the cause.
                if (int_ack) begin
                    state_d = ST_SERVICE;
                    pc_d    = wb_pc;
                end else if (!w_cause_en || !gie) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                in_service = 1'b1;
                if (ertn) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign int_cause = cause_q;
    assign int_pc    = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_ctrl_v2
//  Description : Directed self-checking bench for int_ctrl_v2 (8 external
//                lines, ext0 level-sensitive, all others edge-latched).
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_int_ctrl_v2;

    localparam int unsigned NUM_EXT = 8;
    localparam int unsigned IS_W    = NUM_EXT + 5;

    logic              clk;
    logic              rst_n;
    logic [7:0]        ext_irq;
    logic              timer_irq;
    logic              ipi_irq;
    logic [1:0]        swi;
    logic              timer_clr;
    logic [IS_W-1:0]   is_clr;
    logic              gie;
    logic [IS_W-1:0]   ecfg_lie;
    logic [IS_W-1:0]   estat_is;
    logic              int_req;
    logic [5:0]        int_cause;
    logic              int_ack;
    logic [31:0]       wb_pc;
    logic [31:0]       int_pc;
    logic              ertn;
    logic              in_service;

    int checks = 0;
    int errors = 0;
    int req_cycles;

    int_ctrl_v2 #(
        .NUM_EXT     (NUM_EXT),
        .SYNC_STAGES (2),
        .EDGE_MASK   (8'hFE),
        .PC_W        (32),
        .CAUSE_W     (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ext_irq    (ext_irq),
        .timer_irq  (timer_irq),
        .ipi_irq    (ipi_irq),
        .swi        (swi),
        .timer_clr  (timer_clr),
        .is_clr     (is_clr),
        .gie        (gie),
        .ecfg_lie   (ecfg_lie),
        .estat_is   (estat_is),
        .int_req    (int_req),
        .int_cause  (int_cause),
        .int_ack    (int_ack),
        .wb_pc      (wb_pc),
        .int_pc     (int_pc),
        .ertn       (ertn),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n active edges and settle 1 time unit after the last one.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ext_irq = '0; timer_irq = 1'b0; ipi_irq = 1'b0;
        swi = 2'b01; timer_clr = 1'b0; is_clr = '0; gie = 1'b0;
        ecfg_lie = '0; int_ack = 1'b0; wb_pc = '0; ertn = 1'b0;

        // ---- reset state; swi passes through even in reset ----
        step(3);
        chk("rst_estat", 32'(estat_is), 32'h0001);
        chk("rst_req", 32'(int_req), 32'h0);
        chk("rst_cause", 32'(int_cause), 32'h0);
        chk("rst_pc", int_pc, 32'h0);
        chk("rst_svc", 32'(in_service), 32'h0);
        swi = 2'b00; rst_n = 1'b1;
        step(2);

        // ---- edge ext3 (IS bit 5), one-cycle pulse ----
        ecfg_lie = 13'h0020; gie = 1'b1;
        ext_irq = 8'h08;
        step;                   // sampled high at this edge
        ext_irq = 8'h00;
        step(2);                // pending set on the third edge
        chk("e3_req_early", 32'(int_req), 32'h0);
        chk("e3_pend", 32'(estat_is), 32'h0020);
        step;                   // fourth edge: request
        chk("e3_req", 32'(int_req), 32'h1);
        chk("e3_cause", 32'(int_cause), 32'd5);
        step(3);
        chk("e3_pend_hold", 32'(estat_is), 32'h0020);
        is_clr = 13'h0020;
        step;
        is_clr = '0;
        chk("e3_cleared", 32'(estat_is), 32'h0000);
        chk("e3_req_still", 32'(int_req), 32'h1);
        step;
        chk("e3_withdrawn", 32'(int_req), 32'h0);

        // ---- level ext0 (IS bit 2) high for 3 sampled cycles, no ack ----
        // The IS bit mirrors the input 2 cycles later for 3 cycles; the
        // request lags by one and drops one cycle after the IS bit.
        ecfg_lie = 13'h0004;
        ext_irq = 8'h01;
        step;
        chk("lv_req0", 32'(int_req), 32'h0);
        step;
        chk("lv_is", 32'(estat_is), 32'h0004);
        chk("lv_req1", 32'(int_req), 32'h0);
        step;
        ext_irq = 8'h00;
        chk("lv_req", 32'(int_req), 32'h1);
        chk("lv_cause", 32'(int_cause), 32'd2);
        req_cycles = 1;
        for (int k = 0; k < 6; k++) begin
            step;
            if (int_req) req_cycles++;
        end
        chk("lv_req_cycles", 32'(req_cycles), 32'd3);
        chk("lv_idle", 32'(int_req), 32'h0);
        chk("lv_is_gone", 32'(estat_is), 32'h0000);

        // ---- timer + IPI together, then ack ----
        ecfg_lie = 13'h1FFF;
        timer_irq = 1'b1; ipi_irq = 1'b1;
        step(3);
        chk("ti_ipi_is", 32'(estat_is), 32'h1800);
        chk("ti_ipi_req", 32'(int_req), 32'h1);
        chk("ti_ipi_cause", 32'(int_cause), 32'd12);
        int_ack = 1'b1; wb_pc = 32'h1C00_0040;
        step;
        int_ack = 1'b0; wb_pc = '0;
        chk("ack_req", 32'(int_req), 32'h0);
        chk("ack_svc", 32'(in_service), 32'h1);
        chk("ack_pc", int_pc, 32'h1C00_0040);

        // ---- ack outside REQ is ignored ----
        int_ack = 1'b1; wb_pc = 32'hDEAD_BEEF;
        step;
        int_ack = 1'b0; wb_pc = '0;
        chk("svc_ack_pc", int_pc, 32'h1C00_0040);
        chk("svc_ack_svc", 32'(in_service), 32'h1);

        // ---- new edges during SERVICE, then ertn ----
        ipi_irq = 1'b0; timer_irq = 1'b0; timer_clr = 1'b1;
        step;
        timer_clr = 1'b0;
        ext_irq = 8'h28;        // ext3 -> bit 5, ext5 -> bit 7
        step;
        ext_irq = 8'h00;
        step(4);
        chk("svc_is", 32'(estat_is), 32'h00A0);
        chk("svc_req", 32'(int_req), 32'h0);
        chk("svc_active", 32'(in_service), 32'h1);
        ertn = 1'b1;
        step;
        ertn = 1'b0;
        chk("ertn_svc", 32'(in_service), 32'h0);
        chk("ertn_req", 32'(int_req), 32'h0);
        step;
        chk("rearb_req", 32'(int_req), 32'h1);
        chk("rearb_cause", 32'(int_cause), 32'd7);
        ertn = 1'b1;
        step;
        ertn = 1'b0;
        chk("ertn_in_req", 32'(int_req), 32'h1);
        gie = 1'b0;
        step;
        chk("gie_withdraw", 32'(int_req), 32'h0);
        is_clr = 13'h00A0;
        step;
        is_clr = '0;
        chk("svc_clr", 32'(estat_is), 32'h0000);

        // ---- clear coincident with a new timer rise: set wins ----
        timer_irq = 1'b1;
        step(2);                // rise visible before the next edge
        is_clr = 13'h0800;
        step;
        is_clr = '0;
        chk("ti_isclr_race", 32'(estat_is), 32'h0800);
        timer_clr = 1'b1;
        step;
        timer_clr = 1'b0;
        chk("ti_clr", 32'(estat_is), 32'h0000);
        timer_irq = 1'b0;
        step(4);
        timer_irq = 1'b1;
        step(2);
        timer_clr = 1'b1;
        step;
        timer_clr = 1'b0;
        chk("ti_ticlr_race", 32'(estat_is), 32'h0800);

        // ---- async reset while in REQ ----
        timer_irq = 1'b0;
        step(3);
        gie = 1'b1;
        step;
        chk("pre_rst_req", 32'(int_req), 32'h1);
        chk("pre_rst_cause", 32'(int_cause), 32'd11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(int_req), 32'h0);
        chk("arst_is", 32'(estat_is), 32'h0000);
        step(2);
        rst_n = 1'b1;
        step(6);
        chk("post_rst_is", 32'(estat_is), 32'h0000);
        chk("post_rst_req", 32'(int_req), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
